// File: rtl/delayed_reg_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : delayed_reg_responder_if
//  Brief    : Fabric request/response channel between the delayed-register
//             responder (master) and the fabric-side consumer (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface delayed_reg_responder_if #(
  parameter int DATA_W = 64
);
  logic              fab_req_valid;
  logic              fab_req_ready;
  logic [DATA_W-1:0] fab_req_data;
  logic              fab_rsp_valid;
  logic [DATA_W-1:0] fab_rsp_data;

  // Responder side: issues requests, consumes responses.
  modport master (
    output fab_req_valid,
    output fab_req_data,
    input  fab_req_ready,
    input  fab_rsp_valid,
    input  fab_rsp_data
  );

  // Fabric side: accepts requests, produces responses.
  modport slave (
    input  fab_req_valid,
    input  fab_req_data,
    output fab_req_ready,
    output fab_rsp_valid,
    output fab_rsp_data
  );
endinterface
`default_nettype wire

// File: rtl/delayed_reg_responder.sv
`default_nettype none
// ============================================================================
//  Module   : delayed_reg_responder
//  Brief    : Buffers core-side update strobes in a 2-entry FIFO, issues them
//             one at a time to the fabric, waits for a response or timeout and
//             returns a single-cycle completion pulse with response data.
//  Revision : 1.0 - initial release
// ============================================================================
module delayed_reg_responder #(
  parameter int DATA_W    = 64,
  parameter int TIMEOUT_W = 16
) (
  input  wire logic                 clk,
  input  wire logic                 resetn,
  input  wire logic                 syn_reg1_update,
  input  wire logic [DATA_W-1:0]    wdata,
  input  wire logic [TIMEOUT_W-1:0] timeout_cycles,
  delayed_reg_responder_if.master   fab,
  output logic                      delayed_valid,
  output logic [DATA_W-1:0]         delayed_rdata,
  output logic                      busy,
  output logic                      err_timeout,
  output logic                      err_overflow,
  input  wire logic                 err_clr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_W-1:0]    mem_q [2];
  logic [DATA_W-1:0]    mem_d [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic [DATA_W-1:0]    req_data_q, req_data_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 err_tmo_q, err_tmo_d;
  logic                 err_ovf_q, err_ovf_d;

  logic pop;
  logic push;
  logic ovf_set;
  logic tmo_set;

  // Next-state logic for the FIFO, the request FSM, the timeout counter and
  // the sticky error flags. A zero counter means the timeout is disabled:
  // an enabled counter leaves WAIT when it reaches 1, so it never hits 0.
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    req_data_d = req_data_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    tmo_set    = 1'b0;

    pop     = (state_q == S_IDLE) && (count_q != 2'd0);
    push    = syn_reg1_update && ((count_q != 2'd2) || pop);
    ovf_set = syn_reg1_update && !push;

    // Pop reads the old head before a same-cycle push may reuse that slot.
    if (pop) begin
      req_data_d = mem_q[rd_ptr_q];
      rd_ptr_d   = ~rd_ptr_q;
    end
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ~wr_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (fab.fab_req_ready) begin
          cnt_d   = timeout_cycles;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response in the final timeout cycle still counts as a response.
        if (fab.fab_rsp_valid) begin
          rdata_d = fab.fab_rsp_data;
          state_d = S_RESP;
        end else if (cnt_q == TIMEOUT_W'(1)) begin
          rdata_d = '1;
          tmo_set = 1'b1;
          state_d = S_RESP;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - TIMEOUT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new error event beats a same-cycle clear.
    err_tmo_d = tmo_set | (err_tmo_q & ~err_clr);
    err_ovf_d = ovf_set | (err_ovf_q & ~err_clr);
  end

  // State registers; asynchronous reset discards any queued or in-flight work.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      req_data_q <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_tmo_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      req_data_q <= req_data_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_tmo_q  <= err_tmo_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  // Outputs are decoded from registered state only.
  assign fab.fab_req_valid = (state_q == S_ISSUE);
  assign fab.fab_req_data  = req_data_q;
  assign delayed_valid     = (state_q == S_RESP);
  assign delayed_rdata     = rdata_q;
  assign busy              = (count_q != 2'd0) || (state_q != S_IDLE);
  assign err_timeout       = err_tmo_q;
  assign err_overflow      = err_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_delayed_reg_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_delayed_reg_responder
//  Brief    : Self-checking bench for delayed_reg_responder. Expected timing
//             and data come from a transaction-level view of the handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_delayed_reg_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        syn_reg1_update = 1'b0;
  logic [63:0] wdata = '0;
  logic [15:0] timeout_cycles = '0;
  logic        err_clr = 1'b0;
  logic        delayed_valid;
  logic [63:0] delayed_rdata;
  logic        busy;
  logic        err_timeout;
  logic        err_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  delayed_reg_responder_if #(.DATA_W(64)) fab_if ();

  delayed_reg_responder #(.DATA_W(64), .TIMEOUT_W(16)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .syn_reg1_update (syn_reg1_update),
    .wdata           (wdata),
    .timeout_cycles  (timeout_cycles),
    .fab             (fab_if),
    .delayed_valid   (delayed_valid),
    .delayed_rdata   (delayed_rdata),
    .busy            (busy),
    .err_timeout     (err_timeout),
    .err_overflow    (err_overflow),
    .err_clr         (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=hang required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [63:0] d);
    syn_reg1_update = 1'b1;
    wdata           = d;
    step();
    syn_reg1_update = 1'b0;
  endtask

  // One request into an idle block. rsp_k is the WAIT cycle (1-based) on
  // which the fabric responds, 0 for never. The expected outcome follows the
  // rule: a response on cycles 1..tmo (or any cycle when tmo==0) completes
  // with its data on the next cycle; otherwise the request completes with
  // all-ones at WAIT entry + tmo and flags a timeout.
  task automatic single_txn(input logic [63:0] d, input int rsp_k, input logic [15:0] tmo);
    logic [63:0] r;
    logic [63:0] exp_data;
    logic        exp_err;
    int          done_k;
    r = {$urandom, $urandom};
    if (rsp_k > 0 && (tmo == 0 || rsp_k <= int'(tmo))) begin
      done_k = rsp_k; exp_data = r; exp_err = 1'b0;
    end else begin
      done_k = int'(tmo); exp_data = '1; exp_err = 1'b1;
    end
    err_clr = 1'b1; timeout_cycles = tmo; fab_if.fab_req_ready = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_tmo_cleared", err_timeout, 0);
    upd(d);                                   // now at T+1
    chk("busy_t1", busy, 1);
    chk("no_req_t1", fab_if.fab_req_valid, 0);
    step();                                   // T+2
    chk("req_valid_t2", fab_if.fab_req_valid, 1);
    chk("req_data_t2", fab_if.fab_req_data, d);
    step();                                   // T+3 = WAIT cycle 1
    for (int k = 1; k <= done_k; k++) begin
      fab_if.fab_rsp_valid = (k == rsp_k);
      fab_if.fab_rsp_data  = r;
      chk("no_pulse_wait", delayed_valid, 0);
      step();
    end
    fab_if.fab_rsp_valid = 1'b0;
    chk("pulse", delayed_valid, 1);
    chk("pulse_data", delayed_rdata, exp_data);
    chk("err_tmo", err_timeout, exp_err);
    for (int j = 1; j <= 4; j++) begin
      step();
      fab_if.fab_rsp_valid = ((done_k + j) == rsp_k);
      chk("no_second_pulse", delayed_valid, 0);
    end
    fab_if.fab_rsp_valid = 1'b0;
    step();
    chk("busy_done", busy, 0);
    chk("no_req_done", fab_if.fab_req_valid, 0);
    chk("err_tmo_sticky", err_timeout, exp_err);
  endtask

  // Accept the next request (expected data exp_req), respond on WAIT cycle 1
  // and check the completion. Optionally inject an update on the IDLE cycle
  // that follows the completion pulse.
  task automatic serve_one(input logic [63:0] exp_req, input bit inject, input logic [63:0] inj);
    logic [63:0] r;
    int          i;
    r = {$urandom, $urandom};
    fab_if.fab_req_ready = 1'b1;
    i = 0;
    while (!fab_if.fab_req_valid && i < 30) begin
      step();
      i++;
    end
    chk("serve_req_valid", fab_if.fab_req_valid, 1);
    chk("serve_req_data", fab_if.fab_req_data, exp_req);
    step();
    fab_if.fab_rsp_valid = 1'b1;
    fab_if.fab_rsp_data  = r;
    chk("serve_no_early", delayed_valid, 0);
    step();
    fab_if.fab_rsp_valid = 1'b0;
    chk("serve_pulse", delayed_valid, 1);
    chk("serve_data", delayed_rdata, r);
    step();
    chk("serve_pulse_once", delayed_valid, 0);
    if (inject) upd(inj);
  endtask

  logic [63:0] exp_q[$];
  logic [63:0] a, b, c, d;
  int          rk;
  logic [15:0] tk;

  initial begin
    fab_if.fab_req_ready = 1'b0;
    fab_if.fab_rsp_valid = 1'b0;
    fab_if.fab_rsp_data  = '0;

    // Reset state
    step(); step();
    chk("rst_req_valid", fab_if.fab_req_valid, 0);
    chk("rst_req_data", fab_if.fab_req_data, 0);
    chk("rst_dvalid", delayed_valid, 0);
    chk("rst_rdata", delayed_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_tmo", err_timeout, 0);
    chk("rst_err_ovf", err_overflow, 0);
    resetn = 1'b1;
    step();

    // Single request, response two cycles after WAIT entry
    single_txn(64'h1234, 3, 16'd0);

    // Overflow: first request stalled in ISSUE, then three updates; the
    // FIFO holds two, the third is dropped.
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    c = {$urandom, $urandom}; d = {$urandom, $urandom};
    timeout_cycles = 16'd0;
    fab_if.fab_req_ready = 1'b0;
    upd(a);
    step();
    chk("ovf_issue", fab_if.fab_req_valid, 1);
    upd(b); upd(c);
    chk("ovf_not_yet", err_overflow, 0);
    upd(d);
    chk("ovf_set", err_overflow, 1);
    chk("ovf_req_hold", fab_if.fab_req_data, a);
    step();
    chk("ovf_valid_hold", fab_if.fab_req_valid, 1);
    step();
    exp_q = '{a, b, c};
    while (exp_q.size() > 0) serve_one(exp_q.pop_front(), 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_dropped", fab_if.fab_req_valid, 0);
      step();
    end
    chk("ovf_sticky", err_overflow, 1);
    chk("ovf_idle", busy, 0);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("ovf_clr", err_overflow, 0);

    // Full FIFO in IDLE with a simultaneous push and pop
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    c = {$urandom, $urandom}; d = {$urandom, $urandom};
    fab_if.fab_req_ready = 1'b0;
    upd(a);
    step();
    upd(b); upd(c);
    serve_one(a, 1'b1, d);
    chk("pp_no_ovf", err_overflow, 0);
    exp_q = '{b, c, d};
    while (exp_q.size() > 0) serve_one(exp_q.pop_front(), 1'b0, '0);
    chk("pp_no_ovf_end", err_overflow, 0);
    step();
    chk("pp_idle", busy, 0);

    // Boundary race, disabled timeout and randomized timeout/response mixes
    single_txn({$urandom, $urandom}, 3, 16'd3);
    single_txn({$urandom, $urandom}, 1, 16'd1);
    single_txn({$urandom, $urandom}, 1000, 16'd0);
    for (int n = 0; n < 4; n++) begin
      tk = 16'($urandom_range(1, 6));
      rk = int'($urandom_range(1, 8));
      single_txn({$urandom, $urandom}, rk, tk);
    end

    // Timeout with a late response two cycles after the pulse
    single_txn({$urandom, $urandom}, 6, 16'd4);

    // Reset in WAIT with one entry queued
    timeout_cycles = 16'd0;
    fab_if.fab_req_ready = 1'b1;
    upd({$urandom, $urandom});
    upd({$urandom, $urandom});
    step();
    chk("prerst_busy", busy, 1);
    chk("prerst_err", err_timeout, 1);
    #2 resetn = 1'b0;
    #1;
    chk("mrst_req_valid", fab_if.fab_req_valid, 0);
    chk("mrst_req_data", fab_if.fab_req_data, 0);
    chk("mrst_dvalid", delayed_valid, 0);
    chk("mrst_rdata", delayed_rdata, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_err_tmo", err_timeout, 0);
    chk("mrst_err_ovf", err_overflow, 0);
    step();
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fab_if.fab_rsp_valid = (i == 3);
      step();
      chk("postrst_no_req", fab_if.fab_req_valid, 0);
      chk("postrst_no_pulse", delayed_valid, 0);
      chk("postrst_idle", busy, 0);
    end
    fab_if.fab_rsp_valid = 1'b0;

    // Normal operation resumes after reset
    single_txn({$urandom, $urandom}, 2, 16'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/delayed_reg_responder.md
# delayed_reg_responder

Fabric-side responder for the delayed-register synchronisation handshake. Each core-side update strobe (`syn_reg1_update`) with its write data is buffered in a 2-entry FIFO and issued to the fabric-side consumer over a valid/ready request channel. The block then waits for the fabric response, or for a programmable timeout, and returns a single-cycle `delayed_valid` pulse with response data. That pulse is what releases the core-side wait flag.

## Interface
Parameters:
- DATA_W, 64, width of request and response data
- TIMEOUT_W, 16, width of the timeout counter and `timeout_cycles`

Ports:
- clk  in  1  clock, all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- syn_reg1_update  in  1  update strobe, one request per high cycle
- wdata  in  DATA_W  request data, sampled with `syn_reg1_update`
- timeout_cycles  in  TIMEOUT_W  response timeout in cycles, sampled at request handshake; 0 disables timeout
- fab_req_valid  out  1  request valid to fabric
- fab_req_ready  in  1  fabric accepts request
- fab_req_data  out  DATA_W  request data, stable while `fab_req_valid`
- fab_rsp_valid  in  1  fabric response strobe
- fab_rsp_data  in  DATA_W  response data, sampled with `fab_rsp_valid`
- delayed_valid  out  1  one-cycle completion pulse
- delayed_rdata  out  DATA_W  completion data, valid while `delayed_valid`
- busy  out  1  FIFO non-empty or FSM not IDLE
- err_timeout  out  1  sticky, a request timed out
- err_overflow  out  1  sticky, an update was dropped because the FIFO was full
- err_clr  in  1  clears both sticky errors

## Operation
- FIFO: 2 entries of DATA_W, with a 2-bit count.
  - Push on `syn_reg1_update` when count<2, or when count==2 and a pop occurs in the same cycle.
  - Otherwise drop the update and set `err_overflow`.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the request register and go to ISSUE.
  - ISSUE: `fab_req_valid`=1. On `fab_req_ready`, load the counter with `timeout_cycles` and go to WAIT.
  - WAIT: on `fab_rsp_valid`, latch `fab_rsp_data` into `delayed_rdata` and go to RESP.
    - Otherwise, if timeout is enabled and the counter==1, set `delayed_rdata`={DATA_W{1}}, set `err_timeout`, and go to RESP.
    - Otherwise decrement the counter (only when enabled).
  - RESP: `delayed_valid`=1 for exactly this cycle, then go to IDLE.
- A response and a timeout in the same WAIT cycle: the response wins; no error.
- `fab_rsp_valid` outside WAIT, including a late response after a timeout, is ignored.
- Sticky error set and `err_clr` in the same cycle: set wins.
- Only one request is in flight at a time. Requests complete in FIFO order.

## Timing
- Reset values:
  - State IDLE, FIFO empty, counter 0.
  - `fab_req_valid`=0, `fab_req_data`=0, `delayed_valid`=0, `delayed_rdata`=0, `busy`=0, `err_timeout`=0, `err_overflow`=0.
- Reset asserted mid-operation: all state returns to reset values immediately. The in-flight request and FIFO contents are discarded; no `delayed_valid` is emitted.
- Update at cycle T into an idle block:
  - FIFO non-empty at T+1.
  - ISSUE with `fab_req_valid`=1 at T+2.
  - If `fab_req_ready` is high at T+2, WAIT at T+3.
- Response at WAIT cycle W: `delayed_valid` high at W+1, IDLE at W+2, next ISSUE no earlier than W+3.
- Timeout N: responses are accepted on WAIT cycles 1..N. With no response, RESP occurs at WAIT entry + N.
- `fab_req_valid` stays high and `fab_req_data` stays constant until the handshake. `fab_req_valid` never deasserts without `fab_req_ready`.
- `busy` is registered-state based: high from T+1 after an accepted update until the cycle after the last RESP.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.

## Test plan
- Single request: update wdata=0x1234 at T, ready held high, response 0xABCD two cycles after WAIT entry.
  - Required: `fab_req_valid` at T+2 with data 0x1234; `delayed_valid` one cycle with `delayed_rdata`=0xABCD; `busy` low afterwards.
- Back-to-back, three updates in consecutive cycles while the first is stalled (ready low 5 cycles).
  - Required: first two requests complete in order; third is dropped with `err_overflow`=1.
  - Then `err_clr` → 0.
- Timeout: `timeout_cycles`=4, no response.
  - Required: `delayed_valid` at WAIT entry+4 with `delayed_rdata`=all-ones and `err_timeout`=1.
  - A response arriving 2 cycles later is ignored with no second pulse.
- Race at the boundary: `timeout_cycles`=3, response on WAIT cycle 3.
  - Required: `delayed_rdata`=response data and `err_timeout` stays 0. Separately, with `timeout_cycles`=0 and response after 1000 cycles, completion is normal.
- Reset mid-WAIT: assert `resetn`=0 with the FSM in WAIT and one entry queued.
  - Required: all outputs 0 immediately. After release, no request is issued and no `delayed_valid` occurs until a new update.
- Simultaneous push and pop with the FIFO full in IDLE.
  - Required: update accepted, no overflow; all three requests complete in order.
